// File: rtl/ad_pe_pipe.sv
// Pipelined absolute-difference PE: adds |ref - cur| per lane to a partial-SAD vector behind a
// valid/ready handshake with a two-entry skid buffer. Define AD_PE_SATURATE_EN for clamping lanes.
module ad_pe_pipe #(
    parameter int PIXELS_IN_BATCH           = 16,
    parameter int BIT_DEPTH                 = 8,
    parameter int INPUT_PSAD_BITS_PER_PIXEL = 11,
    parameter int COUNT_BITS                = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]                 in_reference,
    input  logic [BIT_DEPTH-1:0]                                 in_current,
    input  logic [INPUT_PSAD_BITS_PER_PIXEL*PIXELS_IN_BATCH-1:0] in_psad,
    input  logic                                                 in_first,
    input  logic                                                 in_last,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [PIXELS_IN_BATCH*BIT_DEPTH-1:0]                 out_reference,
    output logic [INPUT_PSAD_BITS_PER_PIXEL*PIXELS_IN_BATCH-1:0] out_psad,
    output logic                                                 out_last,
    output logic [COUNT_BITS-1:0]                                beat_count,
    output logic                                                 sat_flag
);

    localparam int W  = INPUT_PSAD_BITS_PER_PIXEL;
    localparam int RW = PIXELS_IN_BATCH * BIT_DEPTH;
    localparam int PW = W * PIXELS_IN_BATCH;

    typedef struct packed {
        logic [RW-1:0] reference;
        logic [PW-1:0] psad;
        logic          last;
    } beat_t;

    beat_t main_q;
    beat_t skid_q;
    beat_t new_beat;
    logic  skid_valid;
    logic  accept;
    logic  transfer;

    logic [PW-1:0]              lane_psad;
    logic [PIXELS_IN_BATCH-1:0] lane_clamp;

    // Ready depends only on the skid register, so out_ready never reaches in_ready combinationally.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    for (genvar i = 0; i < PIXELS_IN_BATCH; i++) begin : g_lane
        logic [BIT_DEPTH-1:0] ref_px;
        logic [BIT_DEPTH-1:0] diff;
        logic [W:0]           base;
        logic [W:0]           sum;

        assign ref_px = in_reference[i*BIT_DEPTH +: BIT_DEPTH];
        assign diff   = (ref_px >= in_current) ? (ref_px - in_current) : (in_current - ref_px);
        assign base   = in_first ? '0 : {1'b0, in_psad[i*W +: W]};
        assign sum    = base + {{(W + 1 - BIT_DEPTH){1'b0}}, diff};
`ifdef AD_PE_SATURATE_EN
        assign lane_psad[i*W +: W] = sum[W] ? {W{1'b1}} : sum[W-1:0];
        assign lane_clamp[i]       = sum[W];
`else
        assign lane_psad[i*W +: W] = sum[W-1:0];
        assign lane_clamp[i]       = 1'b0;
`endif
    end

    assign new_beat = '{reference: in_reference, psad: lane_psad, last: in_last};

    assign out_reference = main_q.reference;
    assign out_psad      = main_q.psad;
    assign out_last      = main_q.last;

    // NOTE: both beat registers, data included, are reset because the out_* fields have
    // defined reset values and a reset mid-stream must discard anything still held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            main_q     <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
            beat_count <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below sees pre-edge register values.
            if (accept) begin
                beat_count <= beat_count + COUNT_BITS'(1);
            end
            if (skid_valid) begin
                if (transfer) begin
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid || out_ready) begin
                    main_q    <= new_beat;
                    out_valid <= 1'b1;
                end else begin
                    skid_q     <= new_beat;
                    skid_valid <= 1'b1;
                end
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef AD_PE_SATURATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (accept && (|lane_clamp)) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign sat_flag = 1'b0;
    logic unused_clamp;
    assign unused_clamp = |lane_clamp;
`endif

endmodule

// File: tb/tb_ad_pe_pipe.sv
// Scoreboard bench for ad_pe_pipe: driver pushes model results on accept, monitor pops on transfer.
// Honours AD_PE_SATURATE_EN the same way the design does.
module tb_ad_pe_pipe;

    localparam int P  = 16;
    localparam int BD = 8;
    localparam int W  = 11;
    localparam int CB = 4;
    localparam int RW = P * BD;
    localparam int PW = P * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] in_reference = '0;
    logic [BD-1:0] in_current = '0;
    logic [PW-1:0] in_psad = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [RW-1:0] out_reference;
    logic [PW-1:0] out_psad;
    logic          out_last;
    logic [CB-1:0] beat_count;
    logic          sat_flag;

    always #5 clk = ~clk;

    ad_pe_pipe #(
        .PIXELS_IN_BATCH(P),
        .BIT_DEPTH(BD),
        .INPUT_PSAD_BITS_PER_PIXEL(W),
        .COUNT_BITS(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reference(in_reference), .in_current(in_current), .in_psad(in_psad),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reference(out_reference), .out_psad(out_psad), .out_last(out_last),
        .beat_count(beat_count), .sat_flag(sat_flag)
    );

    typedef struct {
        logic [RW-1:0] refv;
        logic [PW-1:0] psad;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   bp_hold = 0;
    int   held_accepts = 0;
    bit   model_sat = 1'b0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: per-lane |ref - cur| added to the base with plain integer arithmetic.
    function automatic void model(input logic [RW-1:0] refv, input logic [BD-1:0] cur,
                                  input logic [PW-1:0] psad, input bit first,
                                  output logic [PW-1:0] res, output bit clamped);
        clamped = 1'b0;
        res     = '0;
        for (int i = 0; i < P; i++) begin
            int r = int'(refv[i*BD +: BD]);
            int c = int'(cur);
            int d = (r > c) ? r - c : c - r;
            int s = (first ? 0 : int'(psad[i*W +: W])) + d;
            if (s >= (1 << W)) begin
`ifdef AD_PE_SATURATE_EN
                s       = (1 << W) - 1;
                clamped = 1'b1;
`else
                s = s - (1 << W);
`endif
            end
            res[i*W +: W] = W'(s);
        end
    endfunction

    // Occupancy (accepted minus delivered) fully determines ready/valid as seen from outside.
    task automatic check_status();
        check("in_ready", PW'(in_ready), PW'((n_push - n_pop) < 2));
        check("out_valid", PW'(out_valid), PW'((n_push - n_pop) > 0));
        check("beat_count", PW'(beat_count), PW'(n_push % (1 << CB)));
        check("sat_flag", PW'(sat_flag), PW'(model_sat));
    endtask

    task automatic set_out_ready(input bit rand_bp);
        if (bp_hold > 0) begin
            out_ready = 1'b0;
            bp_hold--;
        end else if (rand_bp) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic drive_beat(input logic [RW-1:0] refv, input logic [BD-1:0] cur,
                              input logic [PW-1:0] psad, input bit first, input bit last,
                              input bit rand_bp);
        exp_t          e;
        logic [PW-1:0] res;
        bit            clamped;
        in_valid     = 1'b1;
        in_reference = refv;
        in_current   = cur;
        in_psad      = psad;
        in_first     = first;
        in_last      = last;
        for (int w = 0; w < 50; w++) begin
            set_out_ready(rand_bp);
            #2;
            check_status();
            if (in_ready) begin
                model(refv, cur, psad, first, res, clamped);
                e.refv = refv;
                e.psad = res;
                e.last = last;
                exp_q.push_back(e);
                n_push++;
                model_sat = model_sat | clamped;
                if (!out_ready) held_accepts++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed low for 50 cycles, expected acceptance");
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            set_out_ready(1'b0);
            #2;
            check_status();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_beat_count", PW'(beat_count), PW'(0));
        check("rst_in_ready", PW'(in_ready), PW'(1));
        check("rst_out_psad", out_psad, PW'(0));
        check("rst_out_last", PW'(out_last), PW'(0));
        check("rst_sat_flag", PW'(sat_flag), PW'(0));
        exp_q.delete();
        n_push    = 0;
        n_pop     = 0;
        model_sat = 1'b0;
        bp_hold   = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops and compares on every transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: psad %0h with empty scoreboard", out_psad);
                end else begin
                    e = exp_q.pop_front();
                    check("out_psad", out_psad, e.psad);
                    check("out_reference", PW'(out_reference), PW'(e.refv));
                    check("out_last", PW'(out_last), PW'(e.last));
                end
                n_pop++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] rv;
        logic [PW-1:0] pv;
        @(posedge clk);
        #1;
        apply_reset();
        idle(2);

        // Single beat: 200 vs 50 on top of 100 gives 250 per lane.
        drive_beat({P{8'd200}}, 8'd50, {P{11'd100}}, 1'b0, 1'b0, 1'b0);
        idle(3);

        // First-row load ignores the incoming partial SAD; also a one-row block.
        drive_beat({P{8'd10}}, 8'd30, {P{11'd2000}}, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Backpressure: out_ready low for three cycles while A..D stream in.
        apply_reset();
        held_accepts = 0;
        bp_hold = 3;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < P; i++) begin
                rv[i*BD +: BD] = BD'($urandom_range(0, 255));
                pv[i*W +: W]   = W'($urandom_range(0, 1500));
            end
            drive_beat(rv, BD'($urandom_range(0, 255)), pv, 1'b0, b == 3, 1'b0);
        end
        idle(4);
        check("bp_held_accepts", PW'(held_accepts), PW'(2));
        check("bp_beat_count", PW'(beat_count), PW'(4));

        // Overflow: 2040 + 255 exceeds the 11-bit lane range.
        drive_beat({P{8'd255}}, 8'd0, {P{11'd2040}}, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Mid-stream reset with two beats buffered.
        bp_hold = 100;
        drive_beat({P{8'd1}}, 8'd2, {P{11'd3}}, 1'b0, 1'b0, 1'b0);
        drive_beat({P{8'd4}}, 8'd5, {P{11'd6}}, 1'b0, 1'b1, 1'b0);
        apply_reset();
        idle(2);

        // Counter wrap: 17 accepts on a 4-bit counter leave it at 1.
        for (int b = 0; b < 17; b++) begin
            drive_beat({P{8'(b * 7)}}, 8'(b * 13), {P{11'(b * 100)}}, 1'b0, 1'b0, 1'b0);
        end
        idle(2);
        check("wrap_beat_count", PW'(beat_count), PW'(1));

        // Random traffic with random backpressure.
        for (int b = 0; b < 400; b++) begin
            for (int i = 0; i < P; i++) begin
                rv[i*BD +: BD] = BD'($urandom_range(0, 255));
                pv[i*W +: W]   = W'($urandom_range(0, 2047));
            end
            drive_beat(rv, BD'($urandom_range(0, 255)), pv, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b1);
        end
        idle(6);
        check("scoreboard_drained", PW'(exp_q.size()), PW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
